// File: rtl/sr_run_ctrl_if.sv
// Host command handshake for sr_run_ctrl: one command per valid/ready transfer.
interface sr_run_ctrl_if #(
    parameter int STEP_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_arg, output cmd_ready);
endinterface

// File: rtl/sr_run_ctrl.sv
// Run/halt/step controller gating the schoolRISCV core clock enable.
// Define SR_RUN_CTRL_OV_TRAP_EN to halt on a rising edge of the core overflow flag.
module sr_run_ctrl #(
    parameter int STEP_W = 16,
    parameter int CYC_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    sr_run_ctrl_if.slave        cmd,
    input  logic                bp_en,
    input  logic [31:0]         bp_addr,
    input  logic [31:0]         pc,
    input  logic                ov_flag,
    output logic                cpu_en,
    output logic [1:0]          state,
    output logic [2:0]          halt_cause,
    output logic [STEP_W-1:0]   steps_left,
    output logic [CYC_W-1:0]    retired
);

    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_RESET     = 3'd0,
        CAUSE_CMD       = 3'd1,
        CAUSE_STEP_DONE = 3'd2,
        CAUSE_BREAK     = 3'd3,
        CAUSE_OV        = 3'd4
    } cause_e;

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0]  CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    cause_e            cause_q, cause_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [CYC_W-1:0]  retired_q, retired_d;
    logic              skip_bp_q, skip_bp_d;
    logic              cmd_ready_q, cmd_ready_d;

    logic              accept_s;
    logic              active_s;
    logic              bp_hit_s;
    logic              trap_pending_s;
    logic              cpu_en_s;
    logic [STEP_W-1:0] step_load_s;

    assign accept_s    = cmd.cmd_valid && cmd_ready_q;
    assign active_s    = (state_q != ST_HALTED);
    // skip_bp lets a resume execute the instruction sitting on the breakpoint.
    assign bp_hit_s    = bp_en && (pc == bp_addr) && !skip_bp_q;
    assign cpu_en_s    = active_s && !bp_hit_s && !trap_pending_s;
    assign step_load_s = (cmd.cmd_arg == {STEP_W{1'b0}}) ? STEP_ONE : cmd.cmd_arg;

`ifdef SR_RUN_CTRL_OV_TRAP_EN
    logic ov_prev_q, ov_prev_d;

    assign ov_prev_d      = ov_flag;
    assign trap_pending_s = active_s && ov_flag && !ov_prev_q;

    // Previous overflow flag for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_prev_q <= 1'b0;
        end else begin
            ov_prev_q <= ov_prev_d;
        end
    end
`else
    logic unused_ov_s;

    assign unused_ov_s    = ov_flag;
    assign trap_pending_s = 1'b0;
`endif

    // Next-state logic; halting events are checked in priority order.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        steps_d     = steps_q;
        retired_d   = retired_q;
        skip_bp_d   = skip_bp_q;
        cmd_ready_d = !accept_s;

        if (accept_s && (cmd.cmd_op == OP_CLEAR)) begin
            retired_d = {CYC_W{1'b0}};
            cause_d   = CAUSE_RESET;
        end else if (cpu_en_s) begin
            retired_d = retired_q + CYC_ONE;
        end else begin
            retired_d = retired_q;
        end

        if (cpu_en_s) begin
            skip_bp_d = 1'b0;
        end else begin
            skip_bp_d = skip_bp_q;
        end

        if (active_s && accept_s && (cmd.cmd_op == OP_HALT)) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_CMD;
            steps_d = {STEP_W{1'b0}};
        end else if (trap_pending_s) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_OV;
        end else if (active_s && bp_hit_s) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_BREAK;
        end else if ((state_q == ST_STEPPING) && cpu_en_s) begin
            steps_d = steps_q - STEP_ONE;
            if (steps_q == STEP_ONE) begin
                state_d = ST_HALTED;
                cause_d = CAUSE_STEP_DONE;
            end else begin
                state_d = state_q;
            end
        end else if (!active_s && accept_s) begin
            case (cmd.cmd_op)
                OP_RUN: begin
                    state_d   = ST_RUNNING;
                    skip_bp_d = 1'b1;
                end
                OP_STEP: begin
                    state_d   = ST_STEPPING;
                    steps_d   = step_load_s;
                    skip_bp_d = 1'b1;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HALTED;
            cause_q     <= CAUSE_RESET;
            steps_q     <= {STEP_W{1'b0}};
            retired_q   <= {CYC_W{1'b0}};
            skip_bp_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            steps_q     <= steps_d;
            retired_q   <= retired_d;
            skip_bp_q   <= skip_bp_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd.cmd_ready = cmd_ready_q;
    assign cpu_en        = cpu_en_s;
    assign state         = state_q;
    assign halt_cause    = cause_q;
    assign steps_left    = steps_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_sr_run_ctrl.sv
// Randomized bench for sr_run_ctrl against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_sr_run_ctrl;
    localparam int STEP_W = 8;
    localparam int CYC_W  = 4;
`ifdef SR_RUN_CTRL_OV_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    logic              clk = 1'b0;
    logic              rst;
    logic              bp_en;
    logic [31:0]       bp_addr;
    logic [31:0]       pc;
    logic              ov_flag;
    logic              cpu_en;
    logic [1:0]        state;
    logic [2:0]        halt_cause;
    logic [STEP_W-1:0] steps_left;
    logic [CYC_W-1:0]  retired;

    sr_run_ctrl_if #(.STEP_W(STEP_W)) cmd_if ();

    sr_run_ctrl #(.STEP_W(STEP_W), .CYC_W(CYC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_if),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .ov_flag    (ov_flag),
        .cpu_en     (cpu_en),
        .state      (state),
        .halt_cause (halt_cause),
        .steps_left (steps_left),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: spec-level quantities only.
    int m_state, m_cause, m_steps, m_retired;
    bit m_skip, m_ready, m_ovp;
    bit last_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output each cycle, then advance the model by one clock.
    always @(negedge clk) begin
        bit acc, running, bp, trap, en;
        int op, arg;
        if (rst) begin
            m_state = 0; m_cause = 0; m_steps = 0; m_retired = 0;
            m_skip = 1'b0; m_ready = 1'b1; m_ovp = 1'b0;
        end
        op      = int'(cmd_if.cmd_op);
        arg     = int'(cmd_if.cmd_arg);
        running = (m_state != 0);
        acc     = !rst && cmd_if.cmd_valid && m_ready;
        bp      = bp_en && (pc == bp_addr) && !m_skip;
        trap    = TRAP_EN && ov_flag && !m_ovp && running;
        en      = running && !bp && !trap;

        check("cmd_ready",  cmd_if.cmd_ready, m_ready);
        check("cpu_en",     cpu_en,           en);
        check("state",      state,            m_state);
        check("halt_cause", halt_cause,       m_cause);
        check("steps_left", steps_left,       m_steps);
        check("retired",    retired,          m_retired);
        last_en = en;

        if (!rst) begin
            if (acc && op == 3) begin
                m_retired = 0;
                m_cause   = 0;
            end else if (en) begin
                m_retired = (m_retired + 1) % (1 << CYC_W);
            end
            if (en) m_skip = 1'b0;

            if (running && acc && op == 0) begin
                m_state = 0; m_cause = 1; m_steps = 0;
            end else if (trap) begin
                m_state = 0; m_cause = 4;
            end else if (running && bp) begin
                m_state = 0; m_cause = 3;
            end else if (m_state == 2 && en) begin
                m_steps = m_steps - 1;
                if (m_steps == 0) begin
                    m_state = 0; m_cause = 2;
                end
            end else if (!running && acc && op == 1) begin
                m_state = 1; m_skip = 1'b1;
            end else if (!running && acc && op == 2) begin
                m_state = 2; m_steps = (arg == 0) ? 1 : arg; m_skip = 1'b1;
            end
            m_ready = !acc;
            m_ovp   = ov_flag;
        end
    end

    // One clock; the core model advances pc by 4 for each enabled cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        if (last_en) pc = pc + 32'd4;
    endtask

    task automatic issue(input logic [1:0] op, input int arg);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_arg   = arg[STEP_W-1:0];
        tick();
        @(negedge clk);
        check("ready_after_accept", cmd_if.cmd_ready, 0);
        tick();
    endtask

    initial begin
        rst = 1'b1; bp_en = 1'b0; bp_addr = 32'd0; pc = 32'd0; ov_flag = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 2'd0; cmd_if.cmd_arg = '0;
        repeat (2) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_cause", halt_cause, 0);
        check("rst_ready", cmd_if.cmd_ready, 1);
        @(posedge clk); #1 rst = 1'b0;
        tick();

        // STEP 3: three enabled cycles then STEP_DONE
        issue(OP_STEP, 3);
        repeat (3) tick();
        @(negedge clk);
        check("step3_state", state, 0);
        check("step3_cause", halt_cause, 2);
        check("step3_steps", steps_left, 0);
        check("step3_retired", retired, 3);

        // STEP 0 behaves as STEP 1
        issue(OP_CLEAR, 0);
        issue(OP_STEP, 0);
        repeat (2) tick();
        @(negedge clk);
        check("step0_retired", retired, 1);
        check("step0_cause", halt_cause, 2);

        // Breakpoint at 0x10 from pc=0
        issue(OP_CLEAR, 0);
        pc = 32'd0; bp_en = 1'b1; bp_addr = 32'h10;
        issue(OP_RUN, 0);
        repeat (4) tick();
        @(negedge clk);
        check("bp_state", state, 0);
        check("bp_cause", halt_cause, 3);
        check("bp_retired", retired, 4);
        check("bp_cpu_en", cpu_en, 0);
        issue(OP_RUN, 0);
        @(negedge clk);
        check("bp_resume_en", cpu_en, 1);
        check("bp_resume_retired", retired, 5);
        issue(OP_HALT, 0);
        @(negedge clk);
        check("bp_halt_retired", retired, 6);
        check("bp_halt_cause", halt_cause, 1);
        bp_en = 1'b0;

        // HALT five cycles after RUN, with a STEP ignored mid-run
        issue(OP_CLEAR, 0);
        pc = 32'd0;
        issue(OP_RUN, 0);
        issue(OP_STEP, 2);
        @(negedge clk);
        check("step_ignored_state", state, 1);
        check("step_ignored_steps", steps_left, 0);
        tick();
        issue(OP_HALT, 0);
        @(negedge clk);
        check("halt_retired", retired, 5);
        check("halt_cause", halt_cause, 1);
        check("halt_state", state, 0);

        // Overflow rising at cycle 7 of a RUN
        issue(OP_CLEAR, 0);
        pc = 32'd0;
        issue(OP_RUN, 0);
        repeat (5) tick();
        ov_flag = 1'b1;
        @(negedge clk);
        check("ov_cpu_en", cpu_en, TRAP_EN ? 0 : 1);
        tick();
        @(negedge clk);
        check("ov_state", state, TRAP_EN ? 0 : 1);
        check("ov_cause", halt_cause, TRAP_EN ? 4 : 0);
        check("ov_retired", retired, TRAP_EN ? 6 : 7);
        issue(OP_HALT, 0);
        issue(OP_RUN, 0);
        @(negedge clk);
        check("ov_rerun_en", cpu_en, 1);
        issue(OP_HALT, 0);
        ov_flag = 1'b0;

        // 17 retirements wrap a 4-bit counter to 1
        issue(OP_CLEAR, 0);
        issue(OP_RUN, 0);
        repeat (15) tick();
        issue(OP_HALT, 0);
        @(negedge clk);
        check("wrap_retired", retired, 1);
        check("wrap_cause", halt_cause, 1);
        issue(OP_CLEAR, 0);
        @(negedge clk);
        check("clear_retired", retired, 0);
        check("clear_cause", halt_cause, 0);
        check("clear_state", state, 0);
        issue(OP_RUN, 0);
        issue(OP_CLEAR, 0);
        @(negedge clk);
        check("clear_run_state", state, 1);
        check("clear_run_retired", retired, 1);

        // Asynchronous reset mid-run
        tick();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_cpu_en", cpu_en, 0);
        check("arst_cause", halt_cause, 0);
        check("arst_retired", retired, 0);
        check("arst_ready", cmd_if.cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic
        pc = 32'd0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) rst = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                cmd_if.cmd_valid = 1'b1;
                cmd_if.cmd_op    = 2'($urandom_range(0, 3));
                cmd_if.cmd_arg   = STEP_W'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 15) == 0) pc = 32'($urandom_range(0, 15)) << 2;
            if (pc > 32'h3C) pc = 32'd0;
            if ($urandom_range(0, 19) == 0) begin
                bp_en   = ~bp_en;
                bp_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if ($urandom_range(0, 24) == 0) ov_flag = ~ov_flag;
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
